// File: rtl/rr_sel_pkg.sv
// Shared constants and helpers for the round-robin / external-select data selector.
package rr_sel_pkg;

  localparam int unsigned MODE_EXT_SEL     = 0;
  localparam int unsigned MODE_ROUND_ROBIN = 1;

  // Ceiling log2 that never returns less than 1, so a 1-channel build still has a select bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned b = 1; b < 32; b++) begin
      if ((64'd1 << b) < 64'(n)) r = b + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_sel_mux_if.sv
// Producer-side channels plus the single consumer-side output of the selector.
interface rr_sel_mux_if
  import rr_sel_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 4
) ();

  localparam int unsigned SELW = clog2_min1(N);

  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [SELW-1:0]    sel;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic [SELW-1:0]    out_chan;

  modport master (
    output in_data, in_valid, sel, out_ready,
    input  in_ready, out_data, out_valid, out_chan
  );

  modport slave (
    input  in_data, in_valid, sel, out_ready,
    output in_ready, out_data, out_valid, out_chan
  );

endinterface

// File: rtl/rr_grant.sv
// Combinational rotating-priority picker: first requester at or after ptr, wrapping modulo N.
module rr_grant #(
  parameter int unsigned N    = 4,
  parameter int unsigned SELW = 2
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [SELW-1:0] idx,
  output logic            any
);

  // Candidate k of the search is channel (ptr + k) mod N; the first requesting candidate wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!any && req[i] &&
            ((32'(ptr) + k == i) || (32'(ptr) + k == i + N))) begin
          grant[i] = 1'b1;
          idx      = SELW'(i);
          any      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rr_sel_mux.sv
// Registered N-to-1 selector with valid/ready on every channel; external select or round-robin.
module rr_sel_mux
  import rr_sel_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 4,
  parameter int unsigned MODE  = MODE_EXT_SEL
) (
  input  logic         clk,
  input  logic         rst,
  rr_sel_mux_if.slave  bus
);

  localparam int unsigned SELW = clog2_min1(N);

  logic [N-1:0]     grant_c;
  logic [SELW-1:0]  idx_c;
  logic             any_c;
  logic             load_ok_c;
  logic             xfer_c;
  logic [WIDTH-1:0] sel_data_c;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]  out_chan_q,  out_chan_d;

  assign load_ok_c = !out_valid_q || bus.out_ready;
  assign xfer_c    = any_c && load_ok_c;

  if (MODE == MODE_ROUND_ROBIN) begin : gen_rr
    logic [SELW-1:0] rr_ptr_q, rr_ptr_d;
    logic            unused_sel;

    assign unused_sel = ^bus.sel;

    rr_grant #(.N(N), .SELW(SELW)) u_grant (
      .req   (bus.in_valid),
      .ptr   (rr_ptr_q),
      .grant (grant_c),
      .idx   (idx_c),
      .any   (any_c)
    );

    // Pointer moves past the winner only when a beat is actually taken.
    always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (xfer_c) begin
        rr_ptr_d = (32'(idx_c) == N - 1) ? '0 : SELW'(32'(idx_c) + 32'd1);
      end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) rr_ptr_q <= '0;
      else     rr_ptr_q <= rr_ptr_d;
    end
  end else begin : gen_ext
    // Direct decode of sel; an out-of-range sel grants nobody.
    always_comb begin
      grant_c = '0;
      idx_c   = '0;
      for (int unsigned i = 0; i < N; i++) begin
        if ((N == 1) || (32'(bus.sel) == i)) begin
          grant_c[i] = bus.in_valid[i];
          idx_c      = SELW'(i);
        end
      end
      any_c = |grant_c;
    end
  end

  // Only the granted channel sees ready, and nobody does while in reset.
  assign bus.in_ready = rst ? '0 : (grant_c & {N{load_ok_c}});

  // One-hot data pick from the granted channel.
  always_comb begin
    sel_data_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant_c[i]) sel_data_c = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  // Output stage: load on a channel transfer, else clear valid once the consumer drains it.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    if (xfer_c) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data_c;
      out_chan_d  = idx_c;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;

endmodule

// File: tb/tb_rr_sel_mux.sv
// Directed bench: external select (N=4 and N=3) and round-robin (N=4) instances side by side.
module tb_rr_sel_mux;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rr_sel_mux_if #(.WIDTH(32), .N(4)) if0 ();
  rr_sel_mux_if #(.WIDTH(32), .N(4)) if1 ();
  rr_sel_mux_if #(.WIDTH(32), .N(3)) if2 ();

  rr_sel_mux #(.WIDTH(32), .N(4), .MODE(0)) u_ext4 (.clk(clk), .rst(rst), .bus(if0.slave));
  rr_sel_mux #(.WIDTH(32), .N(4), .MODE(1)) u_rr4  (.clk(clk), .rst(rst), .bus(if1.slave));
  rr_sel_mux #(.WIDTH(32), .N(3), .MODE(0)) u_ext3 (.clk(clk), .rst(rst), .bus(if2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    if0.in_valid = 4'hF; if1.in_valid = 4'hF; if2.in_valid = 3'h7;
    if0.out_ready = 1'b1; if1.out_ready = 1'b1; if2.out_ready = 1'b1;
    #3;
    for (int r = 0; r < 2; r++) begin
      checks++;
      if (if0.out_valid !== 1'b0 || if0.out_data !== 32'h0 || if0.out_chan !== 2'd0) begin
        errors++;
        $display("FAIL reset_ext4_out: got v=%b d=%h c=%0d expected v=0 d=0 c=0",
                 if0.out_valid, if0.out_data, if0.out_chan);
      end
      checks++;
      if (if1.out_valid !== 1'b0 || if1.out_data !== 32'h0 || if1.out_chan !== 2'd0) begin
        errors++;
        $display("FAIL reset_rr4_out: got v=%b d=%h c=%0d expected v=0 d=0 c=0",
                 if1.out_valid, if1.out_data, if1.out_chan);
      end
      checks++;
      if (if0.in_ready !== 4'h0 || if1.in_ready !== 4'h0 || if2.in_ready !== 3'h0) begin
        errors++;
        $display("FAIL reset_in_ready: got %b %b %b expected 0000 0000 000",
                 if0.in_ready, if1.in_ready, if2.in_ready);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    rst = 1'b0;
    if0.in_valid = '0; if1.in_valid = '0; if2.in_valid = '0;
  endtask

  task automatic test_ext_sel();
    logic [31:0] exp_d [4];
    exp_d = '{32'hAAAA0000, 32'hBBBB0001, 32'hCCCC0002, 32'hDDDD0003};
    if0.in_data   = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    if0.in_valid  = 4'hF;
    if0.out_ready = 1'b1;
    for (int s = 0; s < 4; s++) begin
      if0.sel = 2'(s);
      #1;
      checks++;
      if (if0.in_ready !== (4'b0001 << s)) begin
        errors++;
        $display("FAIL ext_sel_ready[%0d]: got %b expected %b", s, if0.in_ready, 4'b0001 << s);
      end
      @(posedge clk); #1;
      checks++;
      if (if0.out_valid !== 1'b1 || if0.out_data !== exp_d[s] || if0.out_chan !== 2'(s)) begin
        errors++;
        $display("FAIL ext_sel_out[%0d]: got v=%b d=%h c=%0d expected v=1 d=%h c=%0d",
                 s, if0.out_valid, if0.out_data, if0.out_chan, exp_d[s], s);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] sel_t [5];
    logic [3:0] val_t [5];
    sel_t = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd0};
    val_t = '{4'hF, 4'h5, 4'h0, 4'hA, 4'hF};
    if0.in_data   = {32'hDDDD0003, 32'h12345678, 32'hBBBB0001, 32'hAAAA0000};
    if0.sel       = 2'd2;
    if0.in_valid  = 4'hF;
    if0.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (if0.out_data !== 32'h12345678 || if0.out_chan !== 2'd2) begin
      errors++;
      $display("FAIL bp_load: got d=%h c=%0d expected d=12345678 c=2", if0.out_data, if0.out_chan);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if0.out_ready = 1'b0;
      if0.sel       = sel_t[k];
      if0.in_valid  = val_t[k];
      #1;
      checks++;
      if (if0.in_ready !== 4'h0) begin
        errors++;
        $display("FAIL bp_ready[%0d]: got %b expected 0000", k, if0.in_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (if0.out_valid !== 1'b1 || if0.out_data !== 32'h12345678 || if0.out_chan !== 2'd2) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b d=%h c=%0d expected v=1 d=12345678 c=2",
                 k, if0.out_valid, if0.out_data, if0.out_chan);
      end
    end
    @(negedge clk);
    if0.out_ready = 1'b1;
    if0.sel       = 2'd1;
    if0.in_valid  = 4'hF;
    #1;
    checks++;
    if (if0.in_ready !== 4'b0010) begin
      errors++;
      $display("FAIL bp_release_ready: got %b expected 0010", if0.in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (if0.out_valid !== 1'b1 || if0.out_data !== 32'hBBBB0001 || if0.out_chan !== 2'd1) begin
      errors++;
      $display("FAIL bp_release_load: got v=%b d=%h c=%0d expected v=1 d=bbbb0001 c=1",
               if0.out_valid, if0.out_data, if0.out_chan);
    end
    @(negedge clk);
    if0.in_valid = 4'h0;
    @(posedge clk); #1;
    checks++;
    if (if0.out_valid !== 1'b0 || if0.out_data !== 32'hBBBB0001 || if0.out_chan !== 2'd1) begin
      errors++;
      $display("FAIL bp_drain: got v=%b d=%h c=%0d expected v=0 d=bbbb0001 c=1",
               if0.out_valid, if0.out_data, if0.out_chan);
    end
  endtask

  task automatic test_sel_oob();
    @(negedge clk);
    if2.in_data   = {32'h30303030, 32'h20202020, 32'h10101010};
    if2.in_valid  = 3'b111;
    if2.sel       = 2'd0;
    if2.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (if2.out_valid !== 1'b1 || if2.out_data !== 32'h10101010 || if2.out_chan !== 2'd0) begin
      errors++;
      $display("FAIL oob_preload: got v=%b d=%h c=%0d expected v=1 d=10101010 c=0",
               if2.out_valid, if2.out_data, if2.out_chan);
    end
    @(negedge clk);
    if2.sel = 2'd3;
    #1;
    checks++;
    if (if2.in_ready !== 3'b000) begin
      errors++;
      $display("FAIL oob_ready: got %b expected 000", if2.in_ready);
    end
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      checks++;
      if (if2.out_valid !== 1'b0 || if2.out_data !== 32'h10101010) begin
        errors++;
        $display("FAIL oob_drain[%0d]: got v=%b d=%h expected v=0 d=10101010",
                 k, if2.out_valid, if2.out_data);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] data [4];
    data = '{32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003};
    @(negedge clk);
    if1.in_data   = {32'hC0DE0003, 32'hC0DE0002, 32'hC0DE0001, 32'hC0DE0000};
    if1.in_valid  = 4'hF;
    if1.out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      checks++;
      if (if1.in_ready !== (4'b0001 << (c % 4))) begin
        errors++;
        $display("FAIL rr_ready[%0d]: got %b expected %b", c, if1.in_ready, 4'b0001 << (c % 4));
      end
      @(posedge clk); #1;
      checks++;
      if (if1.out_valid !== 1'b1 || if1.out_chan !== 2'(c % 4) || if1.out_data !== data[c % 4]) begin
        errors++;
        $display("FAIL rr_out[%0d]: got v=%b c=%0d d=%h expected v=1 c=%0d d=%h",
                 c, if1.out_valid, if1.out_chan, if1.out_data, c % 4, data[c % 4]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_rr_sparse();
    logic [3:0] exp_r [3];
    logic [1:0] exp_c [3];
    exp_r = '{4'b0010, 4'b1000, 4'b0010};
    exp_c = '{2'd1, 2'd3, 2'd1};
    if1.in_valid = 4'b1010;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (if1.in_ready !== exp_r[c]) begin
        errors++;
        $display("FAIL rr_sparse_ready[%0d]: got %b expected %b", c, if1.in_ready, exp_r[c]);
      end
      @(posedge clk); #1;
      checks++;
      if (if1.out_valid !== 1'b1 || if1.out_chan !== exp_c[c]) begin
        errors++;
        $display("FAIL rr_sparse_chan[%0d]: got v=%b c=%0d expected v=1 c=%0d",
                 c, if1.out_valid, if1.out_chan, exp_c[c]);
      end
      @(negedge clk);
    end
    if1.in_valid  = 4'h0;
    if1.out_ready = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (if1.out_valid !== 1'b1 || if1.out_chan !== 2'd1 || if1.out_data !== 32'hC0DE0001) begin
      errors++;
      $display("FAIL rr_sparse_hold: got v=%b c=%0d d=%h expected v=1 c=1 d=c0de0001",
               if1.out_valid, if1.out_chan, if1.out_data);
    end
  endtask

  task automatic test_async_reset();
    if1.in_valid  = 4'hF;
    if1.out_ready = 1'b1;
    #1;
    checks++;
    if (if1.in_ready !== 4'b0100) begin
      errors++;
      $display("FAIL areset_pre_ptr: got %b expected 0100", if1.in_ready);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (if1.out_valid !== 1'b0 || if1.out_data !== 32'h0 || if1.out_chan !== 2'd0 ||
        if1.in_ready !== 4'h0) begin
      errors++;
      $display("FAIL areset_clear: got v=%b d=%h c=%0d r=%b expected v=0 d=0 c=0 r=0000",
               if1.out_valid, if1.out_data, if1.out_chan, if1.in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (if1.in_ready !== 4'b0001) begin
      errors++;
      $display("FAIL areset_first_ready: got %b expected 0001", if1.in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (if1.out_valid !== 1'b1 || if1.out_chan !== 2'd0 || if1.out_data !== 32'hC0DE0000) begin
      errors++;
      $display("FAIL areset_first_grant: got v=%b c=%0d d=%h expected v=1 c=0 d=c0de0000",
               if1.out_valid, if1.out_chan, if1.out_data);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    if0.in_data = '0; if0.in_valid = '0; if0.sel = '0; if0.out_ready = 1'b0;
    if1.in_data = '0; if1.in_valid = '0; if1.sel = '0; if1.out_ready = 1'b0;
    if2.in_data = '0; if2.in_valid = '0; if2.sel = '0; if2.out_ready = 1'b0;

    test_reset();
    test_ext_sel();
    test_backpressure();
    test_sel_oob();
    test_round_robin();
    test_rr_sparse();
    test_async_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
